// File: rtl/body_upload_arbiter.sv
// body_upload_arbiter: shares the snake segment memory between game-logic moves and the per-frame body upload.
// Define MOVE_WATCHDOG_EN to bound MOVE with a 1023-cycle watchdog that sets sticky wd_error.
module body_upload_arbiter #(
  parameter int SNAKE_LENGTH_BIT = 4,
  parameter int SNAKE_LENGTH_MAX = 16,
  parameter int TRIGGER_Y        = 481
) (
  input  logic                        clock_25,
  input  logic                        reset,
  input  logic [9:0]                  X,
  input  logic [9:0]                  Y,
  input  logic [SNAKE_LENGTH_BIT-1:0] snake_length,
  input  logic                        move_req,
  input  logic                        move_done,
  input  logic [6:0]                  mem_rd_data_x,
  input  logic [6:0]                  mem_rd_data_y,
  output logic [SNAKE_LENGTH_BIT-1:0] mem_rd_addr,
  output logic [SNAKE_LENGTH_BIT-1:0] body_count,
  output logic [6:0]                  snake_body_x,
  output logic [6:0]                  snake_body_y,
  output logic                        body_valid,
  output logic                        move_grant,
  output logic                        semaforo,
  output logic                        frame_done,
  output logic                        wd_error
);
  typedef enum logic [1:0] {IDLE, MOVE, READ, FLUSH} state_t;
  localparam logic [SNAKE_LENGTH_BIT-1:0] N_CAP = SNAKE_LENGTH_BIT'(SNAKE_LENGTH_MAX - 1);
  state_t state, state_nx;
  logic pending, pending_nx, trig, issue, v1;
  logic grant_nx, sem_nx, done_nx;
  logic [SNAKE_LENGTH_BIT-1:0] n, n_nx, cnt, cnt_nx, addr_nx, len_cap, c1;
`ifdef MOVE_WATCHDOG_EN
  logic [9:0] wd_cnt, wd_cnt_nx;
  logic wd_err_nx;
`endif
  assign trig    = (X == 10'd0) && (Y == 10'(TRIGGER_Y));
  assign issue   = (state == READ) && (n != '0);
  assign len_cap = (snake_length > N_CAP) ? N_CAP : snake_length;
  always_comb begin
    state_nx   = state;
    pending_nx = pending | trig;
    n_nx       = n;
    cnt_nx     = cnt;
    addr_nx    = mem_rd_addr;
    grant_nx   = 1'b0;
    sem_nx     = 1'b0;
    done_nx    = 1'b0;
`ifdef MOVE_WATCHDOG_EN
    wd_cnt_nx  = '0;
    wd_err_nx  = wd_error;
`endif
    case (state)
      IDLE: begin
        if (pending || trig) begin
          state_nx   = READ;
          pending_nx = 1'b0;
          n_nx       = len_cap;
          cnt_nx     = '0;
          addr_nx    = '0;
          sem_nx     = 1'b1;
        end else if (move_req) begin
          state_nx = MOVE;
          grant_nx = 1'b1;
        end
      end
      MOVE: begin
        grant_nx = ~move_done;
        state_nx = move_done ? IDLE : MOVE;
`ifdef MOVE_WATCHDOG_EN
        wd_cnt_nx = wd_cnt + 10'd1;
        if (!move_done && wd_cnt == 10'd1022) begin
          state_nx  = IDLE;
          grant_nx  = 1'b0;
          wd_err_nx = 1'b1;
        end
`endif
      end
      READ: begin
        sem_nx = 1'b1;
        if (n == '0 || cnt == n - 1'b1) begin
          state_nx = FLUSH;
          // nothing in flight when N==0, so the drain is cut to a single cycle
          cnt_nx   = (n == '0) ? SNAKE_LENGTH_BIT'(1) : '0;
        end else begin
          cnt_nx  = cnt + 1'b1;
          addr_nx = cnt + 1'b1;
        end
      end
      FLUSH: begin
        state_nx = (cnt == SNAKE_LENGTH_BIT'(1)) ? IDLE : FLUSH;
        done_nx  = (cnt == SNAKE_LENGTH_BIT'(1));
        sem_nx   = (cnt != SNAKE_LENGTH_BIT'(1));
        cnt_nx   = cnt + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      pending      <= 1'b0;
      n            <= '0;
      cnt          <= '0;
      v1           <= 1'b0;
      c1           <= '0;
      mem_rd_addr  <= '0;
      body_count   <= '0;
      snake_body_x <= '0;
      snake_body_y <= '0;
      body_valid   <= 1'b0;
      move_grant   <= 1'b0;
      semaforo     <= 1'b0;
      frame_done   <= 1'b0;
`ifdef MOVE_WATCHDOG_EN
      wd_cnt       <= '0;
      wd_error     <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      pending     <= pending_nx;
      n           <= n_nx;
      cnt         <= cnt_nx;
      mem_rd_addr <= addr_nx;
      move_grant  <= grant_nx;
      semaforo    <= sem_nx;
      frame_done  <= done_nx;
      v1          <= issue;
      c1          <= mem_rd_addr;
      body_valid  <= v1;
      if (v1) begin
        body_count   <= c1;
        snake_body_x <= mem_rd_data_x;
        snake_body_y <= mem_rd_data_y;
      end
`ifdef MOVE_WATCHDOG_EN
      wd_cnt   <= wd_cnt_nx;
      wd_error <= wd_err_nx;
`endif
    end
  end
`ifndef MOVE_WATCHDOG_EN
  assign wd_error = 1'b0;
`endif
endmodule
